// File: rtl/bram_loader.sv
// bram_loader: single-clock image RAM with download loader, CPU port and load status.
// Ports: clk, reset_n (sync, active-low); download: bram_download, bram_wr,
//   bram_init_address, bram_din; CPU: cs, we, addr, din -> dout, dout_valid;
//   status: busy, loaded, load_size, oob.
// Option: define BRAM_LOADER_CLEAR_EN to zero the memory after every reset.
module bram_loader #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 512,
  parameter int WRITABLE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bram_download,
  input  logic              bram_wr,
  input  logic [ADDR_W-1:0] bram_init_address,
  input  logic [DATA_W-1:0] bram_din,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              loaded,
  output logic [ADDR_W:0]   load_size,
  output logic              oob
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
`ifdef BRAM_LOADER_CLEAR_EN
    S_CLEAR,
`endif
    S_IDLE,
    S_LOAD,
    S_READY
  } state_t;

`ifdef BRAM_LOADER_CLEAR_EN
  localparam state_t RST_STATE = S_CLEAR;
  localparam logic   RST_BUSY  = 1'b1;
  logic [IDX_W-1:0] cnt;
`else
  localparam state_t RST_STATE = S_IDLE;
  localparam logic   RST_BUSY  = 1'b0;
`endif

  state_t state;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  cpu_idx;
  logic [IDX_W-1:0]  dl_idx;
  logic [ADDR_W:0]   dl_addr;
  logic [ADDR_W:0]   next_size;
  logic              in_range;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wd;

  assign cpu_idx   = addr[IDX_W-1:0];
  assign dl_idx    = bram_init_address[IDX_W-1:0];
  assign dl_addr   = {1'b0, bram_init_address};
  assign next_size = dl_addr + (ADDR_W+1)'(1);
  assign in_range  = dl_addr < (ADDR_W+1)'(DEPTH);

  // CPU address bits above the index only select mirrors.
  generate
    if (IDX_W < ADDR_W) begin : g_mirror
      logic unused_hi;
      assign unused_hi = ^addr[ADDR_W-1:IDX_W];
    end
  endgenerate

  // Single write port shared by clear, download and CPU.
  // Reset gates it so a strobe during reset never lands.
  always_comb begin
    mem_we  = 1'b0;
    mem_idx = cpu_idx;
    mem_wd  = din;
    if (reset_n) begin
      unique case (state)
`ifdef BRAM_LOADER_CLEAR_EN
        S_CLEAR: begin
          mem_we  = 1'b1;
          mem_idx = cnt;
          mem_wd  = '0;
        end
`endif
        S_LOAD: begin
          if (bram_download && bram_wr && in_range) begin
            mem_we  = 1'b1;
            mem_idx = dl_idx;
            mem_wd  = bram_din;
          end
        end
        S_READY: begin
          if (!bram_download && cs && we && (WRITABLE != 0))
            mem_we = 1'b1;
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_idx] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= RST_STATE;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= RST_BUSY;
      loaded     <= 1'b0;
      load_size  <= '0;
      oob        <= 1'b0;
`ifdef BRAM_LOADER_CLEAR_EN
      cnt        <= '0;
`endif
    end else begin
      dout_valid <= 1'b0;
      unique case (state)
`ifdef BRAM_LOADER_CLEAR_EN
        S_CLEAR: begin
          cnt <= cnt + IDX_W'(1);
          if (cnt == IDX_W'(DEPTH - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
`endif
        S_LOAD: begin
          if (!bram_download) begin
            state  <= S_READY;
            loaded <= 1'b1;
            busy   <= 1'b0;
          end else if (bram_wr) begin
            if (in_range) begin
              if (next_size > load_size)
                load_size <= next_size;
            end else begin
              oob <= 1'b1;
            end
          end
        end
        S_IDLE, S_READY: begin
          if (bram_download) begin
            state     <= S_LOAD;
            busy      <= 1'b1;
            loaded    <= 1'b0;
            load_size <= '0;
            oob       <= 1'b0;
          end else if (cs && !we) begin
            dout       <= mem[cpu_idx];
            dout_valid <= 1'b1;
          end
        end
        default: state <= RST_STATE;
      endcase
    end
  end

endmodule
